// File: rtl/xnor_match_scanner.sv
// Sequential scanner over the XNOR equality map of two operands.
// It reports the match count, the lowest mismatching bit index and a full-equality flag.
module xnor_match_scanner #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4,
    parameter int CW    = 6,
    parameter int IW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    match_count,
    output logic [IW-1:0]    first_mismatch,
    output logic             equal
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] map_reg, map_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [IW-1:0]    fmis_reg, fmis_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             found_reg, found_next;
    logic             in_ready_reg, in_ready_next;
    logic             out_valid_reg, out_valid_next;
    logic [CW-1:0]    match_count_reg, match_count_next;
    logic [IW-1:0]    first_mismatch_reg, first_mismatch_next;
    logic             equal_reg, equal_next;

    logic [SLICE-1:0] slice;
    logic [CW-1:0]    slice_pop;
    logic [IW-1:0]    slice_zpos;
    logic             slice_has_zero;
    logic [CW-1:0]    cnt_sum;
    logic             scan_last;

    assign slice          = map_reg[idx_reg +: SLICE];
    assign slice_has_zero = ~&slice;
    assign cnt_sum        = cnt_reg + slice_pop;
    assign scan_last      = (idx_reg == IW'(WIDTH - SLICE));

    // Popcount of the slice and the position of its lowest zero.
    // The downward walk lets the lowest zero overwrite any higher one.
    always_comb begin
        slice_pop  = '0;
        slice_zpos = '0;
        for (int i = 0; i < SLICE; i++) begin
            slice_pop = slice_pop + CW'(slice[i]);
        end
        for (int i = SLICE - 1; i >= 0; i--) begin
            if (!slice[i]) begin
                slice_zpos = IW'(i);
            end
        end
    end

    always_comb begin
        state_next          = state_reg;
        map_next            = map_reg;
        idx_next            = idx_reg;
        fmis_next           = fmis_reg;
        cnt_next            = cnt_reg;
        found_next          = found_reg;
        in_ready_next       = in_ready_reg;
        out_valid_next      = out_valid_reg;
        match_count_next    = match_count_reg;
        first_mismatch_next = first_mismatch_reg;
        equal_next          = equal_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    map_next      = ~(A ^ B);
                    idx_next      = '0;
                    cnt_next      = '0;
                    fmis_next     = '0;
                    found_next    = 1'b0;
                    in_ready_next = 1'b0;
                    state_next    = SCAN;
                end
            end
            SCAN: begin
                cnt_next = cnt_sum;
                if (!found_reg && slice_has_zero) begin
                    fmis_next  = idx_reg + slice_zpos;
                    found_next = 1'b1;
                end
                idx_next = idx_reg + IW'(SLICE);
                if (scan_last) begin
                    // fmis_next stays 0 when no slice ever held a mismatch.
                    match_count_next    = cnt_sum;
                    first_mismatch_next = fmis_next;
                    equal_next          = (cnt_sum == CW'(WIDTH));
                    out_valid_next      = 1'b1;
                    state_next          = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                in_ready_next  = 1'b1;
                out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            map_reg            <= '0;
            idx_reg            <= '0;
            fmis_reg           <= '0;
            cnt_reg            <= '0;
            found_reg          <= 1'b0;
            in_ready_reg       <= 1'b1;
            out_valid_reg      <= 1'b0;
            match_count_reg    <= '0;
            first_mismatch_reg <= '0;
            equal_reg          <= 1'b0;
        end else begin
            state_reg          <= state_next;
            map_reg            <= map_next;
            idx_reg            <= idx_next;
            fmis_reg           <= fmis_next;
            cnt_reg            <= cnt_next;
            found_reg          <= found_next;
            in_ready_reg       <= in_ready_next;
            out_valid_reg      <= out_valid_next;
            match_count_reg    <= match_count_next;
            first_mismatch_reg <= first_mismatch_next;
            equal_reg          <= equal_next;
        end
    end

    assign in_ready       = in_ready_reg;
    assign out_valid      = out_valid_reg;
    assign match_count    = match_count_reg;
    assign first_mismatch = first_mismatch_reg;
    assign equal          = equal_reg;

endmodule

// File: tb/tb_xnor_match_scanner.sv
// Directed self-checking bench for xnor_match_scanner.
// Inputs are driven on the falling edge and outputs are sampled 1 time unit after the rising edge.
module tb_xnor_match_scanner;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  match_count;
    logic [4:0]  first_mismatch;
    logic        equal;

    int n_checks;
    int n_fail;

    xnor_match_scanner #(
        .WIDTH(32),
        .SLICE(4),
        .CW(6),
        .IW(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .match_count(match_count),
        .first_mismatch(first_mismatch),
        .equal(equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Launches one operation and checks its latency and result.
    // The result handshake is completed only when do_ack is set.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] exp_cnt, input logic [4:0] exp_fm,
                          input logic exp_eq, input bit do_ack);
        int lat;
        @(negedge clk);
        check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd8);
        check_eq("match_count", 32'(match_count), 32'(exp_cnt));
        check_eq("first_mismatch", 32'(first_mismatch), 32'(exp_fm));
        check_eq("equal", 32'(equal), 32'(exp_eq));
        check_eq("in_ready_in_done", 32'(in_ready), 32'd0);
        $display("op A=%08h B=%08h lat=%0d cnt=%0d fmis=%0d eq=%0d", a, b, lat,
                 match_count, first_mismatch, equal);
        if (do_ack) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check_eq("out_valid_after_ack", 32'(out_valid), 32'd0);
            check_eq("in_ready_after_ack", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_match_count", 32'(match_count), 32'd0);
        check_eq("rst_first_mismatch", 32'(first_mismatch), 32'd0);
        check_eq("rst_equal", 32'(equal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd32, 5'd0,  1'b1, 1'b1);
        run_op(32'h0000_0000, 32'h8000_0000, 6'd31, 5'd31, 1'b0, 1'b1);
        run_op(32'h0000_0000, 32'h00F0_0010, 6'd27, 5'd4,  1'b0, 1'b1);
        run_op(32'h1234_5678, 32'hEDCB_A987, 6'd0,  5'd0,  1'b0, 1'b1);

        // Backpressure: the result must stay put and a stray in_valid must be ignored.
        run_op(32'hA5A5_0000, 32'hA5A5_0100, 6'd31, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            A        = '0;
            B        = '0;
            in_valid = (i == 3);
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_match_count", 32'(match_count), 32'd31);
            check_eq("bp_first_mismatch", 32'(first_mismatch), 32'd8);
            check_eq("bp_equal", 32'(equal), 32'd0);
        end
        $display("backpressure held 10 cycles cnt=%0d fmis=%0d", match_count, first_mismatch);
        // in_valid stays high across the handshake edge and must not be taken there.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("hs_out_valid", 32'(out_valid), 32'd0);
        check_eq("hs_in_ready", 32'(in_ready), 32'd1);
        check_eq("hs_count_held", 32'(match_count), 32'd31);
        @(negedge clk);
        in_valid = 1'b0;
        $display("handshake released, in_ready=%0d", in_ready);

        // Reset during the 4th scan cycle.
        @(negedge clk);
        A        = 32'h0000_0000;
        B        = 32'h0000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        check_eq("arst_match_count", 32'(match_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset applied mid-scan");

        run_op(32'h0000_000F, 32'h0000_000E, 6'd31, 5'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xnor_match_scanner.md
Name: xnor_match_scanner

Overview:
- Sequential consumer of the bitwise XNOR equality map of two datapath operands.
- Accepts an A/B pair over a valid/ready handshake and registers the map ~(A^B).
- Scans the map SLICE bits per cycle, LSB first, and returns:
  - the count of matching bits,
  - the index of the lowest mismatching bit,
  - a full-equality flag.
- Sits beside the ALU in the CPU datapath; used by compare/branch-support and debug logic that needs more than a 1-bit equality result.

Parameters:
- WIDTH, 32, operand width in bits.
- SLICE, 4, map bits examined per scan cycle; WIDTH must be a multiple of SLICE.
- CW, 6, width of match_count; must hold WIDTH (clog2(WIDTH+1)).
- IW, 5, width of first_mismatch (clog2(WIDTH)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- match_count  output  CW  number of bit positions where A==B.
- first_mismatch  output  IW  lowest bit index where A!=B; 0 when equal.
- equal  output  1  1 when A==B in all WIDTH bits.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low forces state IDLE immediately, regardless of clock.
  - Reset values: in_ready=1, out_valid=0, match_count=0, first_mismatch=0, equal=0.
  - Internal map, index, accumulator and found flag are cleared.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at a clock edge:
    - map <= ~(A^B); idx <= 0; cnt <= 0; found <= 0.
    - Go to SCAN.
  - A and B need not be held after the accepting edge.
- SCAN (in_ready=0), each cycle:
  - Examine map[idx+SLICE-1:idx].
  - cnt += number of 1s in the slice.
  - If found=0 and the slice contains a 0: fmis <= idx + position of the lowest 0 in the slice; found <= 1.
  - idx += SLICE.
  - Exactly WIDTH/SLICE scan cycles (8 at defaults). On the last one, transfer cnt, fmis (0 if never found) and equal=(final cnt==WIDTH) to the outputs and go to DONE.
- Latency:
  - Accept edge k; out_valid rises after edge k+WIDTH/SLICE (k+8 at defaults).
  - Throughput is one operation per WIDTH/SLICE+2 cycles minimum.
- DONE:
  - out_valid=1; outputs held stable while out_ready=0, for any number of cycles.
  - On out_ready=1 at an edge: out_valid <= 0, go to IDLE, in_ready <= 1 at that same edge.
  - No new operand is accepted in the same cycle as the result handshake.
- Ignored inputs:
  - in_valid in SCAN or DONE is ignored; it does not alter state or outputs.
  - out_ready outside DONE is ignored.
- Output data after the handshake: match_count, first_mismatch and equal keep their last values until the next DONE transfer. They are meaningful only while out_valid=1.
- Arithmetic: cnt is unsigned CW bits and never overflows (max WIDTH). idx wraps only at the DONE transition and is unused there.
- Reset asserted mid-SCAN or in DONE: the in-flight result is discarded. After release the block is in IDLE with in_ready=1.

Test Plan:
- A=0xFFFFFFFF, B=0xFFFFFFFF, accept at edge k -> out_valid rises after edge k+8; match_count=32, equal=1, first_mismatch=0.
- A=0x00000000, B=0x80000000 -> match_count=31, first_mismatch=31, equal=0.
- A=0x00000000, B=0x00F00010 -> match_count=27, first_mismatch=4, equal=0.
- A=0x12345678, B=0xEDCBA987 (all bits differ) -> match_count=0, first_mismatch=0, equal=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulse in_valid with A=B=0 meanwhile -> outputs unchanged, in_ready=0, the pulse is ignored. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 after that edge.
- Reset mid-operation: drop rst_n asynchronously on the 4th SCAN cycle -> out_valid=0 and in_ready=1 immediately. After release, A=0x0000000F, B=0x0000000E -> match_count=31, first_mismatch=0, equal=0.
